// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared widths and FSM state type for the I2C command arbiter
package i2c_arb_pkg;
    localparam int I2C_ADDR_W  = 7;
    localparam int I2C_DATA_W  = 40;
    localparam int I2C_NBYTE_W = 4;
    localparam int I2C_BYTE_W  = 8;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, RUN, DONE} arb_state_t;
endpackage

// File: rtl/i2c_cmd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector; first request at or after ptr wins
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    // scan from lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        logic [IW-1:0] k;
        k = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) idx = k;
        end
        any = |req;
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin sharing of one i2c_master among NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to abort with error when m_busy never rises after m_start.
module i2c_cmd_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0][I2C_ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                     req_rw,
    input  logic [NUM_REQ-1:0][I2C_DATA_W-1:0]     req_data_w,
    input  logic [NUM_REQ-1:0][I2C_NBYTE_W-1:0]    req_n_byte,
    output logic [NUM_REQ-1:0]                     grant,
    output logic [NUM_REQ-1:0]                     done,
    output logic [NUM_REQ-1:0]                     error,
    output logic [NUM_REQ-1:0]                     rd_valid,
    output logic [I2C_BYTE_W-1:0]                  rd_data,
    output logic [I2C_ADDR_W-1:0]                  m_addr,
    output logic                                   m_rw,
    output logic [I2C_DATA_W-1:0]                  m_data_w,
    output logic [I2C_NBYTE_W-1:0]                 m_n_byte,
    output logic                                   m_start,
    input  logic                                   m_busy,
    input  logic                                   m_erro_addr,
    input  logic                                   m_valid_out,
    input  logic [I2C_BYTE_W-1:0]                  m_data_out
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("i2c_cmd_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    arb_state_t         state;
    logic [IW-1:0]      g;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic               err_flag;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]      cnt;
`endif

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // arbitration / sequencing FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            rr_ptr   <= '0;
            err_flag <= 1'b0;
            grant    <= '0;
            done     <= '0;
            error    <= '0;
            rd_valid <= '0;
            rd_data  <= '0;
            m_addr   <= '0;
            m_rw     <= 1'b0;
            m_data_w <= '0;
            m_n_byte <= '0;
            m_start  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            done     <= '0;
            error    <= '0;
            rd_valid <= '0;
            m_start  <= 1'b0;
            case (state)
                IDLE: if (pick_any && !m_busy) begin
                    g        <= pick_idx;
                    grant    <= pick_gnt;
                    m_addr   <= req_addr[pick_idx];
                    m_rw     <= req_rw[pick_idx];
                    m_data_w <= req_data_w[pick_idx];
                    m_n_byte <= req_n_byte[pick_idx];
                    m_start  <= 1'b1;
                    err_flag <= 1'b0;
                    state    <= ISSUE;
                end
                ISSUE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt   <= '0;
`endif
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (m_erro_addr) err_flag <= 1'b1;
                    if (m_busy) state <= RUN;
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
                        err_flag <= 1'b1;
                        done     <= grant;
                        error    <= grant;
                        state    <= DONE;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                RUN: begin
                    if (m_erro_addr) err_flag <= 1'b1;
                    if (m_valid_out) begin
                        rd_valid <= grant;
                        rd_data  <= m_data_out;
                    end
                    if (!m_busy) begin
                        done  <= grant;
                        error <= (err_flag || m_erro_addr) ? grant : '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    grant  <= '0;
                    rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter: randomized bench with an in-bench I2C master and round-robin reference model
module tb_i2c_cmd_arbiter;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic [3:0][6:0]  req_addr = '0;
    logic [3:0]       req_rw = '0;
    logic [3:0][39:0] req_data_w = '0;
    logic [3:0][3:0]  req_n_byte = '0;
    logic [3:0]       grant, done, error, rd_valid;
    logic [7:0]       rd_data;
    logic [6:0]       m_addr;
    logic             m_rw;
    logic [39:0]      m_data_w;
    logic [3:0]       m_n_byte;
    logic             m_start;
    logic             m_busy = 1'b0;
    logic             m_erro_addr = 1'b0;
    logic             m_valid_out = 1'b0;
    logic [7:0]       m_data_out = '0;
    int               total = 0;
    int               bad = 0;
    int               ptr = 0;

    i2c_cmd_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
        .req_data_w(req_data_w), .req_n_byte(req_n_byte), .grant(grant), .done(done),
        .error(error), .rd_valid(rd_valid), .rd_data(rd_data), .m_addr(m_addr),
        .m_rw(m_rw), .m_data_w(m_data_w), .m_n_byte(m_n_byte), .m_start(m_start),
        .m_busy(m_busy), .m_erro_addr(m_erro_addr), .m_valid_out(m_valid_out),
        .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference arbitration: first pending requester at or after the pointer, wrapping
    function automatic int rr_win(input logic [3:0] p, input int s);
        for (int i = 0; i < 4; i++) if (p[2'((s + i) % 4)]) return (s + i) % 4;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [39:0] d, input logic [3:0] n);
        req_addr[2'(i)]   = a;
        req_rw[2'(i)]     = rw;
        req_data_w[2'(i)] = d;
        req_n_byte[2'(i)] = n;
        req[2'(i)]        = 1'b1;
    endtask

    task automatic add_reqs(input int skip);
        for (int i = 0; i < 4; i++)
            if (i != skip && !req[2'(i)] && $urandom_range(0, 1) == 1)
                set_req(i, 7'($urandom), 1'($urandom), {$urandom, 8'($urandom)}, 4'($urandom_range(0, 5)));
    endtask

    task automatic step(input logic [3:0] rdv);
        @(posedge clk); #1;
        chk("rd_valid", 64'(rd_valid), 64'(rdv));
        chk("no_done", 64'(done), 64'(0));
        @(negedge clk);
    endtask

    // one full transaction; entered and left at a negedge with the arbiter idle
    task automatic run_txn(input bit nack, input int dly, input bit drop, input bit rnd);
        int         w, nbytes;
        logic [1:0] wi;
        logic [3:0] oh;
        logic [7:0] b;
        w = rr_win(req, ptr);
        if (w < 0) begin
            chk("have_req", 64'(0), 64'(1));
            return;
        end
        wi = 2'(w);
        oh = 4'(1 << w);
        @(posedge clk); #1;
        chk("grant", 64'(grant), 64'(oh));
        chk("m_start", 64'(m_start), 64'(1));
        chk("m_addr", 64'(m_addr), 64'(req_addr[wi]));
        chk("m_rw", 64'(m_rw), 64'(req_rw[wi]));
        chk("m_data_w", 64'(m_data_w), 64'(req_data_w[wi]));
        chk("m_n_byte", 64'(m_n_byte), 64'(req_n_byte[wi]));
        nbytes = (req_rw[wi] && !nack) ? int'(req_n_byte[wi]) : 0;
        @(negedge clk);
        if (drop) req[wi] = 1'b0;
        if (rnd) add_reqs(w);
        repeat (dly) begin
            step(4'b0);
            chk("grant_hold", 64'(grant), 64'(oh));
            chk("m_start_once", 64'(m_start), 64'(0));
        end
        m_busy = 1'b1;
        repeat (2) step(4'b0);
        if (nack) begin
            m_erro_addr = 1'b1;
            step(4'b0);
            m_erro_addr = 1'b0;
        end
        for (int k = 0; k < nbytes; k++) begin
            if ($urandom_range(0, 1) == 1) step(4'b0);
            b = 8'($urandom);
            m_valid_out = 1'b1;
            m_data_out  = b;
            step(oh);
            chk("rd_data", 64'(rd_data), 64'(b));
            m_valid_out = 1'b0;
        end
        if (nbytes == 0) repeat ($urandom_range(0, 3)) step(4'b0);
        m_busy = 1'b0;
        @(posedge clk); #1;
        chk("done", 64'(done), 64'(oh));
        chk("error", 64'(error), 64'(nack ? oh : 4'b0));
        chk("grant_at_done", 64'(grant), 64'(oh));
        chk("rd_valid_at_done", 64'(rd_valid), 64'(0));
        @(negedge clk);
        req[wi] = 1'b0;
        ptr = (w + 1) % 4;
        @(posedge clk); #1;
        chk("grant_clear", 64'(grant), 64'(0));
        chk("done_pulse", 64'(done), 64'(0));
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_rd_valid", 64'(rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_m_start", 64'(m_start), 64'(0));
        chk("rst_m_addr", 64'(m_addr), 64'(0));
        chk("rst_m_rw", 64'(m_rw), 64'(0));
        chk("rst_m_data_w", 64'(m_data_w), 64'(0));
        chk("rst_m_n_byte", 64'(m_n_byte), 64'(0));
    endtask

    initial begin
        int         w;
        logic [3:0] oh;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // contention: 0, 2, 3 together, then 0 again while 3 is pending
        set_req(0, 7'h10, 1'b0, 40'h11_2233_4455, 4'd1);
        set_req(2, 7'h22, 1'b0, 40'h66_7788_99AA, 4'd2);
        set_req(3, 7'h33, 1'b1, 40'h0, 4'd2);
        run_txn(1'b0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 1, 1'b0, 1'b0);
        set_req(0, 7'h11, 1'b0, 40'hBB_CCDD_EEFF, 4'd0);
        run_txn(1'b0, 2, 1'b0, 1'b0);
        run_txn(1'b0, 0, 1'b0, 1'b0);

        // single write on requester 1, then a read on requester 2, then a NACK
        set_req(1, 7'h50, 1'b0, 40'hA5_C300_0000, 4'd2);
        run_txn(1'b0, 0, 1'b0, 1'b0);
        set_req(2, 7'h48, 1'b1, 40'h0, 4'd3);
        run_txn(1'b0, 0, 1'b0, 1'b0);
        set_req(3, 7'h7F, 1'b1, 40'h0, 4'd4);
        run_txn(1'b1, 1, 1'b0, 1'b0);
        set_req(0, 7'h21, 1'b0, 40'h01_0203_0405, 4'd5);
        run_txn(1'b0, 0, 1'b1, 1'b0);

        // master never raises busy
        set_req(1, 7'h2A, 1'b0, 40'h1, 4'd1);
`ifdef I2C_ARB_TIMEOUT_EN
        w  = rr_win(req, ptr);
        oh = 4'(1 << w);
        @(posedge clk); #1;
        chk("to_grant", 64'(grant), 64'(oh));
        chk("to_m_start", 64'(m_start), 64'(1));
        @(negedge clk);
        repeat (16) step(4'b0);
        @(posedge clk); #1;
        chk("to_done", 64'(done), 64'(oh));
        chk("to_error", 64'(error), 64'(oh));
        @(negedge clk);
        req[2'(w)] = 1'b0;
        ptr = (w + 1) % 4;
        @(posedge clk); #1;
        chk("to_grant_clear", 64'(grant), 64'(0));
        @(negedge clk);
`else
        run_txn(1'b0, 80, 1'b0, 1'b0);
`endif

        for (int t = 0; t < 40; t++) begin
            add_reqs(-1);
            if (req == 4'b0) set_req(int'($urandom_range(0, 3)), 7'($urandom), 1'($urandom),
                                     {$urandom, 8'($urandom)}, 4'($urandom_range(0, 5)));
            run_txn($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0, 1'b1);
        end
        for (int t = 0; t < 4 && req != 4'b0; t++) run_txn(1'b0, 0, 1'b0, 1'b0);

        // reset in the middle of a running transaction
        set_req(2, 7'h33, 1'b1, 40'h0, 4'd4);
        w  = rr_win(req, ptr);
        oh = 4'(1 << w);
        @(posedge clk); #1;
        chk("mid_grant", 64'(grant), 64'(oh));
        @(negedge clk);
        m_busy = 1'b1;
        repeat (3) step(4'b0);
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        set_req(0, 7'h05, 1'b0, 40'hDE_AD00_BEEF, 4'd3);
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        repeat (4) begin
            step(4'b0);
            chk("no_grant_busy", 64'(grant), 64'(0));
        end
        m_busy = 1'b0;
        run_txn(1'b0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
